// File: rtl/profile_timer_ctrl_if.sv
// Avalon-style 16-bit register port of the 64-bit profile timer.
// The master side is the sequencing controller; the slave side is the timer.
interface profile_timer_ctrl_if;
    logic [3:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata, tmr_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata, tmr_irq
    );
endinterface

// File: rtl/profile_timer_ctrl.sv
// Sequencer that turns level requests into profile-timer register sequences:
// configure/start, stop, 64-bit snapshot readback and interrupt servicing.
module profile_timer_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_req,
    input  logic [63:0]          cfg_period,
    input  logic                 cfg_continuous,
    input  logic                 cfg_ito,
    output logic                 cfg_ack,
    input  logic                 stop_req,
    output logic                 stop_ack,
    input  logic                 snap_req,
    output logic                 snap_ack,
    output logic [63:0]          snap_value,
    output logic                 timeout_pulse,
    output logic [CNT_W-1:0]     timeout_count,
    output logic                 busy,
    profile_timer_ctrl_if.master tmr
);

    typedef enum logic [3:0] {
        S_IDLE, S_IRQ_CLR, S_STOP,
        S_CFG_W0, S_CFG_W1, S_CFG_W2, S_CFG_W3, S_CFG_CTRL,
        S_SNAP_W, S_SNAP_R0, S_SNAP_R1, S_SNAP_R2, S_SNAP_R3,
        S_SNAP_DONE, S_SNAP_ACK
    } state_t;

    state_t             state, state_next;
    logic [63:0]        period_q;
    logic               cont_q, ito_q;
    logic [63:0]        shadow;
    logic [63:0]        snap_q;
    logic [CNT_W-1:0]   count;
    logic               cfg_accept;

    logic [3:0]         bus_addr;
    logic               bus_cs;
    logic               bus_wn;
    logic [15:0]        bus_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Bus, acks and pulses decode from state and registered config only,
    // so no request input reaches the timer port combinationally.
    always_comb begin
        state_next    = state;
        bus_addr      = '0;
        bus_cs        = 1'b0;
        bus_wn        = 1'b1;
        bus_data      = '0;
        cfg_ack       = 1'b0;
        stop_ack      = 1'b0;
        snap_ack      = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (tmr.tmr_irq)   state_next = S_IRQ_CLR;
                else if (stop_req) state_next = S_STOP;
                else if (cfg_req)  state_next = S_CFG_W0;
                else if (snap_req) state_next = S_SNAP_W;
            end
            S_IRQ_CLR: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd0;
                timeout_pulse = 1'b1;
                state_next = S_IDLE;
            end
            S_STOP: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd1;
                bus_data = {12'd0, 1'b1, 1'b0, cont_q, ito_q};
                stop_ack = 1'b1;
                state_next = S_IDLE;
            end
            S_CFG_W0: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd2;
                bus_data = period_q[15:0];
                state_next = S_CFG_W1;
            end
            S_CFG_W1: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd3;
                bus_data = period_q[31:16];
                state_next = S_CFG_W2;
            end
            S_CFG_W2: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd4;
                bus_data = period_q[47:32];
                state_next = S_CFG_W3;
            end
            S_CFG_W3: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd5;
                bus_data = period_q[63:48];
                state_next = S_CFG_CTRL;
            end
            S_CFG_CTRL: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd1;
                bus_data = {12'd0, 1'b0, 1'b1, cont_q, ito_q};
                cfg_ack = 1'b1;
                state_next = S_IDLE;
            end
            S_SNAP_W: begin
                bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 4'd6;
                state_next = S_SNAP_R0;
            end
            S_SNAP_R0: begin
                bus_cs = 1'b1; bus_addr = 4'd6;
                state_next = S_SNAP_R1;
            end
            S_SNAP_R1: begin
                bus_cs = 1'b1; bus_addr = 4'd7;
                state_next = S_SNAP_R2;
            end
            S_SNAP_R2: begin
                bus_cs = 1'b1; bus_addr = 4'd8;
                state_next = S_SNAP_R3;
            end
            S_SNAP_R3: begin
                bus_cs = 1'b1; bus_addr = 4'd9;
                state_next = S_SNAP_DONE;
            end
            S_SNAP_DONE: state_next = S_SNAP_ACK;
            S_SNAP_ACK: begin
                snap_ack = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cfg_accept = (state == S_IDLE) && (state_next == S_CFG_W0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            shadow   <= '0;
            snap_q   <= '0;
            count    <= '0;
        end else begin
            if (cfg_accept) begin
                period_q <= cfg_period;
                cont_q   <= cfg_continuous;
                ito_q    <= cfg_ito;
            end
            if (state == S_IRQ_CLR) count <= count + CNT_W'(1);
            // Read data lags its address by one cycle; the visible value is
            // loaded in one step so it never shows a partial snapshot.
            case (state)
                S_SNAP_R1: shadow[15:0]  <= tmr.tmr_readdata;
                S_SNAP_R2: shadow[31:16] <= tmr.tmr_readdata;
                S_SNAP_R3: shadow[47:32] <= tmr.tmr_readdata;
                S_SNAP_DONE: begin
                    shadow[63:48] <= tmr.tmr_readdata;
                    snap_q        <= {tmr.tmr_readdata, shadow[47:0]};
                end
                default: ;
            endcase
        end
    end

    assign tmr.tmr_address    = bus_addr;
    assign tmr.tmr_chipselect = bus_cs;
    assign tmr.tmr_write_n    = bus_wn;
    assign tmr.tmr_writedata  = bus_data;
    assign snap_value         = snap_q;
    assign timeout_count      = count;
    assign busy               = (state != S_IDLE);

endmodule

// File: doc/profile_timer_ctrl.md
# profile_timer_ctrl

Sequencing controller that sits between client logic and the 16-bit Avalon-style register port of the 64-bit profile timer. It turns level requests into the exact register-write and read sequences the timer needs: configure period and start, stop, snapshot and 64-bit readback. It also services and clears the timer interrupt. Only this block drives the timer's slave port.

## Interface
- CNT_W, 16, width of the timeout event counter
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_req  in  1  level; request to load period and start
- cfg_period  in  64  period value, sampled in IDLE when cfg_req is accepted
- cfg_continuous  in  1  continuous mode bit, sampled with cfg_period
- cfg_ito  in  1  interrupt enable bit, sampled with cfg_period
- cfg_ack  out  1  one-cycle pulse: configure sequence complete
- stop_req  in  1  level; request to stop the timer
- stop_ack  out  1  one-cycle pulse: stop written
- snap_req  in  1  level; request a counter snapshot
- snap_ack  out  1  one-cycle pulse: snap_value valid and updated
- snap_value  out  64  last snapshot; holds until the next snapshot
- timeout_pulse  out  1  one-cycle pulse per serviced interrupt
- timeout_count  out  CNT_W  serviced-interrupt count; wraps
- busy  out  1  high whenever state is not IDLE
- tmr_address  out  4  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write strobe
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  timer read data; registered in the timer, valid one cycle after the address is driven
- tmr_irq  in  1  timer interrupt, level

## Operation
- Timer register map:
  - 0: status. A write clears the timeout flag.
  - 1: control, bits 3..0 = stop, start, continuous, ito.
  - 2..5: period halfwords 0..3. A write forces a reload and stops the timer.
  - 6..9: snapshot halfwords 0..3. A write to any of them latches the counter.
- Bus idle value: chipselect 0, write_n 1, address 0, writedata 0. This is also the reset value.
- Write cycle: chipselect 1, write_n 0, address and data valid, exactly one cycle.
- Read cycle: chipselect 1, write_n 1, address valid.
- Arbitration is evaluated only in IDLE, with fixed priority tmr_irq > stop_req > cfg_req > snap_req.
- Requests are level. The requester must drop its req in its ack cycle. A req still high in the following IDLE cycle counts as a new request.
- IDLE -> IRQ_CLR:
  - Writes address 0 with data 0.
  - timeout_pulse is 1 in this cycle.
  - timeout_count increments at the end of the cycle, wrapping from 2^CNT_W-1 to 0.
  - Returns to IDLE.
- IDLE -> STOP:
  - Writes address 1 with {1,0,cont_q,ito_q}, where cont_q/ito_q are the last configured bits.
  - stop_ack is 1 in this cycle.
  - Returns to IDLE.
- IDLE -> CFG_W0..CFG_W3 -> CFG_CTRL:
  - On acceptance, latches cfg_period, cfg_continuous and cfg_ito.
  - CFG_Wn writes address 2+n with period[16n+15:16n].
  - CFG_CTRL writes address 1 with {0,1,cont_q,ito_q}; cfg_ack is 1 in this cycle.
  - Returns to IDLE.
- IDLE -> SNAP_W -> SNAP_R0..SNAP_R3 -> SNAP_DONE -> SNAP_ACK -> IDLE:
  - SNAP_W writes address 6 with data 0.
  - SNAP_Rn reads address 6+n.
  - Each halfword is captured one cycle after its address: R1 captures hw0, R2 captures hw1, R3 captures hw2, DONE captures hw3.
  - Captured halfwords go to a shadow register. snap_value loads all 64 bits at the end of SNAP_DONE.
  - snap_ack is 1 in SNAP_ACK. snap_value never shows a partial update.
- busy = (state != IDLE).
- Limitation: if tmr_irq rises again in the IRQ_CLR cycle, the timer's status write wins and that event is lost.

## Timing
- Latency, with the request accepted in IDLE cycle t:
  - IRQ_CLR and STOP write at t+1.
  - cfg writes at t+1..t+4; control write and cfg_ack at t+5; IDLE at t+6.
  - Snapshot write at t+1; reads at t+2..t+5; snap_ack at t+7 with new snap_value; IDLE at t+8.
- tmr_irq falls at the edge that ends IRQ_CLR, so the next IDLE cycle does not re-service it.
- All outputs come from registers or direct state decode. No combinational path runs from any req to tmr_*.
- Reset asserted at any time, mid-sequence included:
  - State goes to IDLE and the bus to idle immediately.
  - snap_value, shadow, timeout_count, cont_q and ito_q clear to 0.
  - All acks and pulses go to 0.
  - The partial timer sequence is abandoned. The timer has its own reset and is not cleared by this one.

## Test plan
- Reset, then cfg_req with period 0x0000_0000_0001_86A0, continuous=1, ito=1 -> writes (2,0x86A0), (3,0x0001), (4,0), (5,0) at t+1..t+4; (1,0x0007) at t+5; cfg_ack at t+5 only.
- Timer stub returns halfwords 0x1111/0x2222/0x3333/0x4444 one cycle after addresses 6..9; snap_req -> write to address 6 at t+1; snap_ack at t+7; snap_value=0x4444_3333_2222_1111, unchanged during t+2..t+6.
- tmr_irq, stop_req and cfg_req rise in the same IDLE cycle -> IRQ_CLR (write 0 to address 0), then STOP (write 0x000B to address 1 after the previous config), then the cfg sequence. timeout_count becomes 1.
- CNT_W=4 with 16 serviced interrupts -> timeout_count wraps to 0; 16 timeout_pulses observed.
- Reset asserted during SNAP_R2 -> same-cycle bus idle, busy=0, snap_value=0, no snap_ack. A later snap_req completes normally.
- cfg_req held high through cfg_ack and one extra cycle -> a second full cfg sequence starts in the next IDLE cycle.
